// File: rtl/ch0re_types.sv
// Shared types for the ch0re pipeline: memory op/size encodings and the MEM-stage FSM states.
package ch0re_types;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } mem_state_e;

    // Natural alignment within a doubleword: the low log2(size) address bits must be zero.
    function automatic logic is_misaligned(input logic [2:0] lane, input mem_size_e size);
        case (size)
            SZ_H:    return lane[0];
            SZ_W:    return |lane[1:0];
            SZ_D:    return |lane;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ch0re_mem_align.sv
// Combinational lane logic: alignment check, byte enables and store shift on the request side,
// load extraction and sign/zero extension on the response side.
module ch0re_mem_align
    import ch0re_types::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      req_lane,
    input  mem_size_e       req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic            req_misaligned,
    output logic [7:0]      req_be,
    output logic [XLEN-1:0] req_wdata_sh,
    input  logic [2:0]      rsp_lane,
    input  mem_size_e       rsp_size,
    input  logic            rsp_unsigned,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] rsp_data
);

    logic [XLEN-1:0] rsp_shifted;

    always_comb begin
        req_misaligned = is_misaligned(req_lane, req_size);
        req_be         = 8'hFF;
        case (req_size)
            SZ_B:    req_be = 8'h01 << req_lane;
            SZ_H:    req_be = 8'h03 << req_lane;
            SZ_W:    req_be = 8'h0F << req_lane;
            default: req_be = 8'hFF;
        endcase
        req_wdata_sh = req_wdata << {req_lane, 3'b000};
    end

    always_comb begin
        rsp_shifted = rsp_rdata >> {rsp_lane, 3'b000};
        rsp_data    = rsp_shifted;
        case (rsp_size)
            SZ_B: rsp_data = {{(XLEN-8){~rsp_unsigned & rsp_shifted[7]}}, rsp_shifted[7:0]};
            SZ_H: rsp_data = {{(XLEN-16){~rsp_unsigned & rsp_shifted[15]}}, rsp_shifted[15:0]};
            SZ_W: rsp_data = {{(XLEN-32){~rsp_unsigned & rsp_shifted[31]}}, rsp_shifted[31:0]};
            default: rsp_data = rsp_shifted;
        endcase
    end

endmodule

// File: rtl/ch0re_mem_stage.sv
// MEM pipeline stage: turns EX results into data-memory loads/stores over a req/gnt/rvalid port
// and hands single-cycle results to WB. One op in flight; EX is stalled via o_ready.
module ch0re_mem_stage
    import ch0re_types::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_mem_op,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_rd_we,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_rd_we,
    output logic [XLEN-1:0]   o_data,
    output logic              o_misaligned,
    output logic              o_dmem_req,
    input  logic              i_dmem_gnt,
    output logic              o_dmem_we,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic [7:0]        o_dmem_be,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_rvalid,
    input  logic [XLEN-1:0]   i_dmem_rdata
);

    mem_state_e state_q, state_d;

    // Op context captured on accept
    mem_op_e           op_q, op_d;
    mem_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic [2:0]        lane_q, lane_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rd_we_lat_q, rd_we_lat_d;

    // Registered outputs
    logic              valid_q, valid_d;
    logic              rd_we_q, rd_we_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              misal_q, misal_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   daddr_q, daddr_d;
    logic [7:0]        be_q, be_d;
    logic [XLEN-1:0]   dwdata_q, dwdata_d;

    mem_op_e           in_op;
    mem_size_e         in_size;
    logic              accept;
    logic              req_misaligned;
    logic [7:0]        req_be;
    logic [XLEN-1:0]   req_wdata_sh;
    logic [XLEN-1:0]   load_data;

    assign in_op   = mem_op_e'(i_mem_op);
    assign in_size = mem_size_e'(i_size);
    assign o_ready = (state_q == StIdle);
    assign accept  = i_valid & o_ready;

    ch0re_mem_align #(
        .XLEN (XLEN)
    ) u_align (
        .req_lane       (i_addr[2:0]),
        .req_size       (in_size),
        .req_wdata      (i_wdata),
        .req_misaligned (req_misaligned),
        .req_be         (req_be),
        .req_wdata_sh   (req_wdata_sh),
        .rsp_lane       (lane_q),
        .rsp_size       (size_q),
        .rsp_unsigned   (uns_q),
        .rsp_rdata      (i_dmem_rdata),
        .rsp_data       (load_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        rd_we_lat_d = rd_we_lat_q;
        valid_d     = 1'b0;
        rd_we_d     = 1'b0;
        misal_d     = 1'b0;
        data_d      = data_q;
        req_d       = req_q;
        we_d        = we_q;
        daddr_d     = daddr_q;
        be_d        = be_q;
        dwdata_d    = dwdata_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d        = in_op;
                    size_d      = in_size;
                    uns_d       = i_unsigned;
                    lane_d      = i_addr[2:0];
                    rd_d        = i_rd;
                    rd_we_lat_d = i_rd_we;
                    if (in_op == MEM_NONE) begin
                        valid_d = 1'b1;
                        rd_we_d = i_rd_we;
                        data_d  = i_addr;
                    end else if (req_misaligned) begin
                        // Fault retires without touching memory; report the faulting address
                        valid_d = 1'b1;
                        misal_d = 1'b1;
                        data_d  = i_addr;
                    end else begin
                        state_d  = StReq;
                        req_d    = 1'b1;
                        we_d     = (in_op == MEM_STORE);
                        daddr_d  = {i_addr[XLEN-1:3], 3'b000};
                        be_d     = req_be;
                        dwdata_d = req_wdata_sh;
                    end
                end
            end
            StReq: begin
                if (i_dmem_gnt) begin
                    req_d = 1'b0;
                    if (op_q == MEM_STORE) begin
                        state_d = StIdle;
                        valid_d = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (i_dmem_rvalid) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    rd_we_d = rd_we_lat_q;
                    data_d  = load_data;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            op_q        <= MEM_NONE;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            rd_q        <= '0;
            rd_we_lat_q <= 1'b0;
            valid_q     <= 1'b0;
            rd_we_q     <= 1'b0;
            data_q      <= '0;
            misal_q     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            daddr_q     <= '0;
            be_q        <= '0;
            dwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            rd_we_lat_q <= rd_we_lat_d;
            valid_q     <= valid_d;
            rd_we_q     <= rd_we_d;
            data_q      <= data_d;
            misal_q     <= misal_d;
            req_q       <= req_d;
            we_q        <= we_d;
            daddr_q     <= daddr_d;
            be_q        <= be_d;
            dwdata_q    <= dwdata_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_rd         = rd_q;
    assign o_rd_we      = rd_we_q;
    assign o_data       = data_q;
    assign o_misaligned = misal_q;
    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = daddr_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = dwdata_q;

endmodule

// File: tb/tb_ch0re_mem_stage.sv
// Directed bench for ch0re_mem_stage: pass-through, loads, stores, misalignment and reset abort.
module tb_ch0re_mem_stage;
    import ch0re_types::*;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [1:0]  mem_op;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        rd_we;
    logic        o_valid;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic [63:0] o_data;
    logic        o_misaligned;
    logic        dmem_req;
    logic        dmem_gnt;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    ch0re_mem_stage #(
        .XLEN   (64),
        .REG_AW (5)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_mem_op      (mem_op),
        .i_size        (size),
        .i_unsigned    (uns),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_rd          (rd),
        .i_rd_we       (rd_we),
        .o_valid       (o_valid),
        .o_rd          (o_rd),
        .o_rd_we       (o_rd_we),
        .o_data        (o_data),
        .o_misaligned  (o_misaligned),
        .o_dmem_req    (dmem_req),
        .i_dmem_gnt    (dmem_gnt),
        .o_dmem_we     (dmem_we),
        .o_dmem_addr   (dmem_addr),
        .o_dmem_be     (dmem_be),
        .o_dmem_wdata  (dmem_wdata),
        .i_dmem_rvalid (dmem_rvalid),
        .i_dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r,
                         input logic we);
        valid  = 1'b1;
        mem_op = op;
        size   = sz;
        uns    = u;
        addr   = a;
        wdata  = wd;
        rd     = r;
        rd_we  = we;
    endtask

    // Aligned load: accept, hold REQ for gnt_wait extra cycles, then rvalid after rv_wait idle cycles.
    task automatic run_load(input string tag, input logic [1:0] sz, input logic u,
                            input logic [63:0] a, input logic [63:0] rdata,
                            input logic [63:0] exp_addr, input logic [7:0] exp_be,
                            input logic [63:0] exp_data, input int gnt_wait, input int rv_wait);
        issue(MEM_LOAD, sz, u, a, 64'h0, 5'd10, 1'b1);
        tick();
        valid = 1'b0;
        chk({tag, "_req"}, 64'(dmem_req), 64'd1);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_be"}, 64'(dmem_be), 64'(exp_be));
        chk({tag, "_we"}, 64'(dmem_we), 64'd0);
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            chk({tag, "_req_hold"}, 64'(dmem_req), 64'd1);
            chk({tag, "_ready_req"}, 64'(ready), 64'd0);
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk({tag, "_req_drop"}, 64'(dmem_req), 64'd0);
        for (int i = 0; i < rv_wait; i++) begin
            chk({tag, "_ready_wait"}, 64'(ready), 64'd0);
            chk({tag, "_novalid"}, 64'(o_valid), 64'd0);
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        dmem_rvalid = 1'b0;
        chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        chk({tag, "_data"}, o_data, exp_data);
        chk({tag, "_rd"}, 64'(o_rd), 64'd10);
        chk({tag, "_rd_we"}, 64'(o_rd_we), 64'd1);
        chk({tag, "_misal"}, 64'(o_misaligned), 64'd0);
        chk({tag, "_ready_back"}, 64'(ready), 64'd1);
        tick();
        chk({tag, "_pulse"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 64'h0;
        issue(MEM_NONE, SZ_B, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        valid = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_be", 64'(dmem_be), 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        rst = 1'b0;

        // Pass-through, back to back
        issue(MEM_NONE, SZ_D, 1'b0, 64'hDEAD_BEEF, 64'h0, 5'd5, 1'b1);
        tick();
        chk("none_valid", 64'(o_valid), 64'd1);
        chk("none_data", o_data, 64'hDEAD_BEEF);
        chk("none_rd", 64'(o_rd), 64'd5);
        chk("none_rd_we", 64'(o_rd_we), 64'd1);
        chk("none_ready", 64'(ready), 64'd1);
        issue(MEM_NONE, SZ_D, 1'b0, 64'h55, 64'h0, 5'd7, 1'b0);
        tick();
        valid = 1'b0;
        chk("none2_valid", 64'(o_valid), 64'd1);
        chk("none2_data", o_data, 64'h55);
        chk("none2_rd", 64'(o_rd), 64'd7);
        chk("none2_rd_we", 64'(o_rd_we), 64'd0);
        tick();
        chk("none_pulse", 64'(o_valid), 64'd0);

        run_load("lb", SZ_B, 1'b0, 64'h1003, 64'h0000_0000_8000_0000, 64'h1000, 8'h08,
                 64'hFFFF_FFFF_FFFF_FF80, 2, 3);
        run_load("lbu", SZ_B, 1'b1, 64'h1003, 64'h0000_0000_8000_0000, 64'h1000, 8'h08,
                 64'h80, 0, 1);
        run_load("lwu", SZ_W, 1'b1, 64'h1004, 64'hCAFE_BABE_1234_5678, 64'h1000, 8'hF0,
                 64'hCAFE_BABE, 1, 0);
        run_load("lh", SZ_H, 1'b0, 64'h5002, 64'h0000_0000_9ABC_0000, 64'h5000, 8'h0C,
                 64'hFFFF_FFFF_FFFF_9ABC, 0, 0);

        // Halfword store into the top lane
        issue(MEM_STORE, SZ_H, 1'b0, 64'h2006, 64'h1234, 5'd9, 1'b1);
        tick();
        valid = 1'b0;
        chk("sh_req", 64'(dmem_req), 64'd1);
        chk("sh_we", 64'(dmem_we), 64'd1);
        chk("sh_addr", dmem_addr, 64'h2000);
        chk("sh_be", 64'(dmem_be), 64'hC0);
        chk("sh_wdata", dmem_wdata, 64'h1234_0000_0000_0000);
        chk("sh_ready", 64'(ready), 64'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("sh_valid", 64'(o_valid), 64'd1);
        chk("sh_rd_we", 64'(o_rd_we), 64'd0);
        chk("sh_req_drop", 64'(dmem_req), 64'd0);
        chk("sh_ready_back", 64'(ready), 64'd1);

        // Misaligned word load never reaches memory
        issue(MEM_LOAD, SZ_W, 1'b0, 64'h3002, 64'h0, 5'd4, 1'b1);
        tick();
        valid = 1'b0;
        chk("mis_req", 64'(dmem_req), 64'd0);
        chk("mis_valid", 64'(o_valid), 64'd1);
        chk("mis_flag", 64'(o_misaligned), 64'd1);
        chk("mis_rd_we", 64'(o_rd_we), 64'd0);
        chk("mis_ready", 64'(ready), 64'd1);
        tick();
        chk("mis_pulse", 64'(o_misaligned), 64'd0);

        // Reset while waiting for load data, then a stray rvalid
        issue(MEM_LOAD, SZ_D, 1'b0, 64'h4000, 64'h0, 5'd12, 1'b1);
        tick();
        valid = 1'b0;
        chk("abort_be", 64'(dmem_be), 64'hFF);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("abort_in_wait", 64'(ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_req", 64'(dmem_req), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h1111_2222_3333_4444;
        tick();
        dmem_rvalid = 1'b0;
        chk("stray_valid", 64'(o_valid), 64'd0);
        chk("stray_ready", 64'(ready), 64'd1);
        issue(MEM_NONE, SZ_D, 1'b0, 64'h77, 64'h0, 5'd3, 1'b1);
        tick();
        valid = 1'b0;
        chk("post_valid", 64'(o_valid), 64'd1);
        chk("post_data", o_data, 64'h77);
        chk("post_rd", 64'(o_rd), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
